// File: rtl/spi_controller.sv
// SPI mode-0 master (MSB first) behind a 4-register CPU interface: DATA, STATUS, DIVIDER, SELECT.
// Define SPI_IRQ_EN to add the irq_n output and a writable interrupt enable in STATUS bit 0.
module spi_controller #(
   parameter logic [7:0] DIV_RESET = 8'd3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       phi2,
   input  logic       read_write,
   input  logic       io_spi_n,
   input  logic       write_enable,
   input  logic [1:0] per_addr,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
`ifdef SPI_IRQ_EN
   output logic       irq_n,
`endif
   output logic [3:0] ss_n
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;

   logic [1:0] state;
   logic [7:0] tx_sh;
   logic [7:0] rx_sh;
   logic [7:0] rx_r;
   logic [7:0] div_r;
   logic [7:0] hcnt;
   logic [2:0] bit_cnt;
   logic [3:0] ss_r;
   logic       done;
   logic       overrun;
   logic       wr_prev;
   logic       phi2_prev;
   logic       irq_en;
   logic       wr_lvl;
   logic       wr_stb;
   logic       rd_clr;
   logic       busy;

   // One strobe per CPU write however long write_enable stays asserted.
   assign wr_lvl = write_enable && !io_spi_n;
   assign wr_stb = wr_lvl && !wr_prev;
   assign rd_clr = phi2_prev && !phi2 && !io_spi_n && read_write && (per_addr == 2'd0);
   assign busy   = (state != IDLE);
   assign sclk   = (state == HIGH);
   assign mosi   = tx_sh[7];
   assign ss_n   = ss_r;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         tx_sh     <= 8'h00;
         rx_sh     <= 8'h00;
         rx_r      <= 8'h00;
         div_r     <= DIV_RESET;
         hcnt      <= 8'h00;
         bit_cnt   <= 3'd0;
         ss_r      <= 4'hF;
         done      <= 1'b0;
         overrun   <= 1'b0;
         wr_prev   <= 1'b0;
         phi2_prev <= 1'b0;
      end else begin
         wr_prev   <= wr_lvl;
         phi2_prev <= phi2;
         if (wr_stb && per_addr == 2'd2) div_r <= data_in;
         if (wr_stb && per_addr == 2'd3) ss_r <= data_in[3:0];
         if (wr_stb && per_addr == 2'd1 && data_in[5]) overrun <= 1'b0;
         if (wr_stb && per_addr == 2'd0 && busy) overrun <= 1'b1;
         // Clears are issued first so a completion later in this block wins.
         if ((wr_stb && per_addr == 2'd1 && data_in[6]) || rd_clr) done <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_stb && per_addr == 2'd0) begin
                  tx_sh   <= data_in;
                  done    <= 1'b0;
                  bit_cnt <= 3'd0;
                  hcnt    <= div_r;
                  state   <= LOW;
               end
            end
            LOW: begin
               if (hcnt == 8'h00) begin
                  rx_sh <= {rx_sh[6:0], miso};
                  hcnt  <= div_r;
                  state <= HIGH;
               end else begin
                  hcnt <= hcnt - 8'd1;
               end
            end
            HIGH: begin
               if (hcnt == 8'h00) begin
                  if (bit_cnt == 3'd7) begin
                     rx_r  <= rx_sh;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     tx_sh   <= {tx_sh[6:0], 1'b0};
                     bit_cnt <= bit_cnt + 3'd1;
                     hcnt    <= div_r;
                     state   <= LOW;
                  end
               end else begin
                  hcnt <= hcnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_IRQ_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq_n  <= 1'b1;
      end else begin
         if (wr_stb && per_addr == 2'd1) irq_en <= data_in[0];
         irq_n <= !(irq_en && done);
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   always_comb begin
      data_out = 8'h00;
      case (per_addr)
         2'd0:    data_out = rx_r;
         2'd1:    data_out = {busy, done, overrun, 4'b0000, irq_en};
         2'd2:    data_out = div_r;
         default: data_out = {4'h0, ss_r};
      endcase
   end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: timeline model of each transfer plus CPU-side register model,
// compared on every falling clk edge, with randomized register traffic and directed scenarios.
`timescale 1ns/1ps
module tb_spi_controller;
   logic       clk;
   logic       reset_n;
   logic       phi2;
   logic       read_write;
   logic       io_spi_n;
   logic       write_enable;
   logic [1:0] per_addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [3:0] ss_n;
`ifdef SPI_IRQ_EN
   logic       irq_n;
`endif
   logic       miso_drv;

   int checks = 0;
   int errors = 0;

   // Model state
   bit         chk_en = 0;
   bit         m_active = 0;
   longint     m_ts = 0;
   int         m_d = 0;
   logic [7:0] m_tx = 0, m_mi = 0, m_rx = 0, m_div = 8'd3;
   logic [3:0] m_ss = 4'hF;
   bit         m_done = 0, m_ovr = 0, m_irq_en = 0, m_loop = 0, m_idle_mosi = 0;
   bit         p_done = 0, p_irq_en = 0;
   logic [7:0] next_mi = 0;
   bit         next_loop = 0;

   assign miso = m_loop ? mosi : miso_drv;

   always #3 clk = ~clk;

   spi_controller dut (
      .clk(clk), .reset_n(reset_n), .phi2(phi2), .read_write(read_write),
      .io_spi_n(io_spi_n), .write_enable(write_enable), .per_addr(per_addr),
      .data_in(data_in), .data_out(data_out), .sclk(sclk), .mosi(mosi), .miso(miso),
`ifdef SPI_IRQ_EN
      .irq_n(irq_n),
`endif
      .ss_n(ss_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_rx = 8'h00; m_div = 8'd3; m_ss = 4'hF;
      m_done = 0; m_ovr = 0; m_irq_en = 0; m_idle_mosi = 0; m_loop = 0;
      p_done = 0; p_irq_en = 0;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [7:0] d);
      case (a)
         2'd0: begin
            if (m_active) m_ovr = 1;
            else begin
               m_active = 1; m_ts = longint'($time); m_d = int'(m_div); m_tx = d;
               m_done = 0; m_mi = next_mi; m_loop = next_loop;
            end
         end
         2'd1: begin
            if (d[6]) m_done = 0;
            if (d[5]) m_ovr = 0;
`ifdef SPI_IRQ_EN
            m_irq_en = d[0];
`endif
         end
         2'd2: m_div = d;
         default: m_ss = d[3:0];
      endcase
   endtask

   // A transfer is a timeline: offset o after the start edge lies in bit o/(2*hp),
   // low for the first hp clocks of each bit and high for the next hp.
   always @(negedge clk) begin : cmp
      logic [7:0] exp_do;
      bit e_sclk, e_mosi, e_busy;
      int o, hp, b;
      if (chk_en) begin
         e_sclk = 0; e_busy = 0; e_mosi = m_idle_mosi;
         if (m_active) begin
            hp = m_d + 1;
            o = int'((longint'($time) - 3 - m_ts) / 6);
            if (o >= 16 * hp) begin
               m_active = 0; m_done = 1;
               m_rx = m_loop ? m_tx : m_mi;
               m_idle_mosi = m_tx[0]; e_mosi = m_tx[0];
            end else begin
               e_busy = 1;
               b = o / (2 * hp);
               e_sclk = (o % (2 * hp)) >= hp;
               e_mosi = m_tx[7 - b];
               miso_drv = m_mi[7 - b];
            end
         end
         case (per_addr)
            2'd0:    exp_do = m_rx;
            2'd1:    exp_do = {e_busy, m_done, m_ovr, 4'b0000, m_irq_en};
            2'd2:    exp_do = m_div;
            default: exp_do = {4'h0, m_ss};
         endcase
         check("sclk", sclk, e_sclk);
         check("mosi", mosi, e_mosi);
         check("ss_n", ss_n, m_ss);
         check("data_out", data_out, exp_do);
`ifdef SPI_IRQ_EN
         check("irq_n", irq_n, !(p_irq_en && p_done));
`endif
         p_done = m_done; p_irq_en = m_irq_en;
      end
   end

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int hold);
      @(posedge clk); #1;
      io_spi_n = 0; write_enable = 1; read_write = 0; per_addr = a; data_in = d;
      @(posedge clk);
      model_write(a, d);
      repeat (hold - 1) @(posedge clk);
      #1; write_enable = 0; io_spi_n = 1; per_addr = 2'd1;
   endtask

   task automatic cpu_read(input logic [1:0] a, output logic [7:0] v);
      @(posedge clk); #1;
      io_spi_n = 0; read_write = 1; per_addr = a; phi2 = 1;
      @(posedge clk); #1;
      v = data_out;
      phi2 = 0;
      @(posedge clk);
      if (a == 2'd0) m_done = 0;
      #1; io_spi_n = 1; read_write = 0; per_addr = 2'd1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; reset_n = 0;
      @(posedge clk);
      model_reset(); chk_en = 1;
      #1; reset_n = 1;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (m_active && n < budget) begin
         @(posedge clk); n++;
      end
      if (m_active) begin
         checks++; errors++;
         $display("FAIL wait_idle timeout after %0d clk", budget);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1; per_addr = 2'($urandom);
   endtask

   logic [7:0] v;
   logic [7:0] bits;
   int busy_cnt, high_cnt;
   bit prev_sclk;

   initial begin
      clk = 0; reset_n = 0; phi2 = 0; read_write = 0; io_spi_n = 1;
      write_enable = 0; per_addr = 2'd1; data_in = 8'h00; miso_drv = 0;
      do_reset();
      @(negedge clk);
      check("rst_status", data_out, 8'h00);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ss_n", ss_n, 4'hF);
      cpu_read(2'd2, v);
      check("rst_div", v, 8'd3);

      // div 0, loopback, A5
      cpu_write(2'd2, 8'h00, 1);
      next_loop = 1;
      cpu_write(2'd0, 8'hA5, 1);
      busy_cnt = 0; bits = 0; prev_sclk = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (data_out[7]) busy_cnt++;
         if (sclk && !prev_sclk) bits = {bits[6:0], mosi};
         prev_sclk = sclk;
      end
      check("a5_busy_clks", busy_cnt, 16);
      check("a5_mosi_bits", bits, 8'hA5);
      wait_idle(200);
      cpu_read(2'd1, v); check("a5_status_done", v, 8'h40);
      cpu_read(2'd0, v); check("a5_rx", v, 8'hA5);
      cpu_read(2'd1, v); check("a5_status_cleared", v, 8'h00);

      // div 3, miso tied high, send 00
      cpu_write(2'd2, 8'h03, 1);
      next_loop = 0; next_mi = 8'hFF;
      cpu_write(2'd0, 8'h00, 1);
      busy_cnt = 0; high_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (data_out[7]) busy_cnt++;
         if (sclk) high_cnt++;
      end
      check("ff_busy_clks", busy_cnt, 64);
      check("ff_sclk_high_clks", high_cnt, 32);
      wait_idle(200);
      cpu_read(2'd0, v); check("ff_rx", v, 8'hFF);
      cpu_read(2'd1, v); check("ff_done_cleared", v, 8'h00);

      // second DATA write during a transfer
      cpu_write(2'd2, 8'h01, 1);
      next_loop = 1;
      cpu_write(2'd0, 8'h3C, 1);
      cpu_write(2'd0, 8'hC3, 1);
      cpu_read(2'd1, v); check("ovr_status", v, 8'hA0);
      cpu_write(2'd1, 8'h20, 1);
      cpu_read(2'd1, v); check("ovr_cleared", v, 8'h80);
      wait_idle(200);
      cpu_read(2'd0, v); check("ovr_rx_unaltered", v, 8'h3C);

      // reset during bit 4
      cpu_write(2'd3, 8'h05, 1);
      next_loop = 0; next_mi = 8'($urandom);
      cpu_write(2'd0, 8'($urandom), 1);
      repeat (18) @(posedge clk);
      do_reset();
      @(negedge clk);
      check("abort_sclk", sclk, 0);
      check("abort_ss_n", ss_n, 4'hF);
      check("abort_status", data_out, 8'h00);
      cpu_read(2'd2, v); check("abort_div", v, 8'd3);

      // long write_enable pulses
      cpu_write(2'd3, 8'h0E, 10);
      @(negedge clk); check("sel_ss_n", ss_n, 4'hE);
      cpu_write(2'd0, 8'h5A, 10);
      cpu_read(2'd1, v); check("held_data_single", v, 8'h80);
      wait_idle(200);

      // maximum divider
      cpu_write(2'd2, 8'hFF, 1);
      next_loop = 0; next_mi = 8'($urandom);
      cpu_write(2'd0, 8'($urandom), 1);
      busy_cnt = 0;
      for (int i = 0; i < 4200; i++) begin
         @(negedge clk);
         if (data_out[7]) busy_cnt++;
      end
      check("div_ff_busy_clks", busy_cnt, 4096);
      wait_idle(100);

`ifdef SPI_IRQ_EN
      cpu_write(2'd2, 8'h00, 1);
      cpu_write(2'd1, 8'h01, 1);
      cpu_write(2'd0, 8'h81, 1);
      wait_idle(200);
      @(negedge clk); @(negedge clk);
      check("irq_asserted", irq_n, 0);
      cpu_read(2'd0, v);
      @(negedge clk); @(negedge clk);
      check("irq_released", irq_n, 1);
`endif

      // randomized register traffic
      wait_idle(5000);
      cpu_write(2'd2, 8'h01, 1);
      for (int i = 0; i < 60; i++) begin
         int op;
         op = int'($urandom_range(0, 7));
         next_mi = 8'($urandom); next_loop = bit'($urandom_range(0, 1));
         case (op)
            0, 1: cpu_write(2'd0, 8'($urandom), int'($urandom_range(1, 3)));
            2: if (!m_active) cpu_write(2'd2, 8'($urandom_range(0, 3)), 1);
               else idle(1);
            3: cpu_write(2'd3, 8'($urandom), 1);
            4: cpu_write(2'd1, 8'($urandom), 1);
            5: cpu_read(2'd0, v);
            6: cpu_read(2'd1, v);
            default: idle(int'($urandom_range(1, 20)));
         endcase
      end
      wait_idle(5000);
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter DIV_RESET, default 8'd3, reset value of the DIVIDER register.
REQ-002 SHALL have ports: clk, input, 1, system clock (6 ns period).
REQ-003 SHALL have ports: reset_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have ports: phi2, input, 1, CPU clock.
REQ-005 SHALL have ports: read_write, input, 1, CPU read/write (read high).
REQ-006 SHALL have ports: io_spi_n, input, 1, device select from the bus controller (active low).
REQ-007 SHALL have ports: write_enable, input, 1, write data valid level from the bus controller.
REQ-008 SHALL have ports: per_addr, input, 2, register index (peripheral address bits 1:0).
REQ-009 SHALL have ports: data_in, input, 8, write data.
REQ-010 SHALL have ports: data_out, output, 8, read data, combinational mux.
REQ-011 SHALL have ports: sclk, output, 1, SPI clock (mode 0, idle low).
REQ-012 SHALL have ports: mosi, output, 1, SPI data out, MSB first.
REQ-013 SHALL have ports: miso, input, 1, SPI data in.
REQ-014 SHALL have ports: ss_n, output, 4, slave selects (active low).
REQ-015 SHALL have ports: irq_n, output, 1, interrupt request (active low); present only per REQ-036.

Function
REQ-016 Register map: 0 DATA, 1 STATUS, 2 DIVIDER, 3 SELECT.
- DATA read returns rx_r.
- STATUS read returns {busy, done, overrun, 4'b0, irq_en}.
- DIVIDER read returns div_r.
- SELECT read returns {4'h0, ss_r}.
REQ-017 Write strobe SHALL be a single clk pulse on the first clk where write_enable and !io_spi_n are both true (rising-edge detect); each CPU write SHALL act exactly once.
REQ-018 Read side effect SHALL occur on the clk where phi2 falls (phi2 registered high, current low) with !io_spi_n, read_write high and per_addr==0.
REQ-019 Strobe to DIVIDER SHALL load div_r; strobe to SELECT SHALL load ss_r from data_in[3:0]; ss_n SHALL equal ss_r.
REQ-020 Strobe to STATUS:
- data_in[6]=1 clears done.
- data_in[5]=1 clears overrun.
- data_in[0] loads irq_en.
- busy is read-only.
REQ-021 The state machine SHALL have states IDLE, LOW (sclk=0), HIGH (sclk=1).
REQ-022 A DATA strobe in IDLE SHALL:
- load tx shift register;
- clear done;
- reset bit counter to 0;
- load half-period counter with div_r;
- enter LOW.
busy SHALL read 1 on the next clk.
REQ-023 In LOW/HIGH the half-period counter SHALL decrement each clk. When the counter is 0 and in LOW, the controller SHALL sample miso into the rx shift LSB, go to HIGH and reload div_r. sclk half period = div_r+1 clk.
REQ-024 When the counter is 0 in HIGH, the controller SHALL shift tx left, increment the bit counter and go to LOW with reload. If the bit counter was 7, it SHALL instead go to IDLE, copy the rx shift into rx_r, set done and leave sclk low.
REQ-025 mosi SHALL equal the tx shift MSB at all times; it SHALL be valid for at least div_r+1 clk before each sclk rise.
REQ-026 Total busy time SHALL be exactly 16*(div_r+1) clk (div_r=0 gives 16 clk); done SHALL rise on the same clk busy falls.
REQ-027 A DATA strobe while busy SHALL NOT alter the transfer and SHALL set sticky overrun.
REQ-028 A div_r change mid-transfer SHALL take effect at the next half-period reload only.
REQ-029 A DATA read SHALL clear done. If a transfer completes on the same clk, set SHALL win.
REQ-030 A STATUS clear of done on the same clk as completion: set SHALL win.
REQ-031 The 8-bit counter arithmetic SHALL wrap naturally; div_r=8'hFF SHALL give a 256-clk half period.

Reset
REQ-032 On reset_n low at clk rise, the controller SHALL enter IDLE with the following values:
- sclk=0, mosi=0, ss_n=4'hF.
- rx_r=0, busy=0, done=0, overrun=0, irq_en=0.
- div_r=DIV_RESET.
- irq_n=1.
REQ-033 Reset mid-transfer SHALL abort immediately with the REQ-032 values; no done SHALL be produced.
REQ-034 The write-edge and phi2 history registers SHALL reset to 0 so no spurious strobe follows reset.

Configuration
REQ-035 Macro SPI_IRQ_EN SHALL gate interrupt support.
REQ-036 With SPI_IRQ_EN defined, irq_n SHALL equal !(irq_en && done), registered, and STATUS bit0 SHALL be writable.
REQ-037 Without SPI_IRQ_EN, the irq_n port and irq_en logic SHALL be absent and STATUS bit0 SHALL read 0.

Verification
REQ-038 div=0, write DATA=8'hA5, miso looped to mosi -> busy for exactly 16 clk; mosi bits 1,0,1,0,0,1,0,1 at sclk rises; rx_r=8'hA5; done=1.
REQ-039 div=3, miso tied 1, write DATA=8'h00 -> sclk high/low 4 clk each; busy 64 clk; DATA reads 8'hFF; done cleared after the read.
REQ-040 Write DATA twice within one transfer -> second write ignored; STATUS reads 8'hA0 during busy; after STATUS write 8'h20, overrun=0.
REQ-041 Reset asserted at bit 4 of a transfer -> next clk: sclk=0, ss_n=4'hF, busy=0, done=0, div_r=DIV_RESET.
REQ-042 write_enable held high 10 clk for a SELECT write of 8'h0E -> ss_n=4'hE, single strobe; write DATA twice back-to-back in one phi2 cycle produces one transfer.
REQ-043 With SPI_IRQ_EN: irq_en=1, complete a transfer -> irq_n goes to 0 one clk after done; DATA read -> irq_n returns to 1.
